elink_frame_rx76: RTL and testbench

Host-side e-link receiver for the MOPSHUB uplink. It deserializes the 2-bit e-link stream driven on `tx_elink2bit` and locks onto frame delimiters. It recovers each 76-bit uplink frame, the same word MOPSHUB presents internally as `data_rec_uplink`, and flags framing errors. It sits in the test environment and host-emulation path, opposite the MOPSHUB e-link transmitter.

---
 rtl/mopshub_elink_pkg.sv | 19 +
 rtl/elink_dibit_deser.sv | 44 ++++
 rtl/elink_frame_rx76.sv | 151 +++++++++++++++
 tb/tb_elink_frame_rx76.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mopshub_elink_pkg.sv
// mopshub_elink_pkg
//   Shared e-link line constants and receiver state encoding. This package is
//   meant to be shared by the host-side receiver and the e-link transmitter
//   model.
//   No ports (package only).
package mopshub_elink_pkg;

  localparam logic [7:0] ELINK_SOP  = 8'h3C;
  localparam logic [7:0] ELINK_EOP  = 8'hDC;
  localparam logic [7:0] ELINK_IDLE = 8'hBC;
  localparam int         UPLINK_W   = 76;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    EOP     = 2'd2
  } elink_rx_state_t;

endpackage

// File: rtl/elink_dibit_deser.sv
// elink_dibit_deser
//   Collects the 2-bit e-link stream into bytes. The shift register runs every
//   clock, whatever the receiver state. A 2-bit phase counter marks the byte
//   boundary. The receiver resets that counter to the alignment of the SOP
//   it found.
// Ports:
//   i_clk          e-link clock
//   i_rst          synchronous active-low reset
//   i_realign      restart the phase count (driven on SOP match)
//   i_dibit        serial dibit, bit[1] earlier in time
//   o_byte_q       last four dibits, oldest in bits [7:6]
//   o_byte_strobe  high when o_byte_q holds a complete byte after realignment
module elink_dibit_deser (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_realign,
  input  logic [1:0] i_dibit,
  output logic [7:0] o_byte_q,
  output logic       o_byte_strobe
);

  logic [7:0] r_sr;
  logic [1:0] r_phase;

  // The realign edge sets the phase to 0. Four dibits later the phase reads 3.
  // At that point r_sr holds exactly the first byte after the SOP.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_sr    <= '0;
      r_phase <= '0;
    end else begin
      r_sr <= {r_sr[5:0], i_dibit};
      if (i_realign) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + 2'd1;
      end
    end
  end

  assign o_byte_q      = r_sr;
  assign o_byte_strobe = (r_phase == 2'd3);

endmodule

// File: rtl/elink_frame_rx76.sv
// elink_frame_rx76
//   Host-side e-link receiver for the MOPSHUB uplink. It searches the dibit
//   stream for SOP and collects FRAME_BYTES payload bytes. It then checks for
//   EOP and a zero top nibble. A good frame updates o_data_out, pulses
//   o_data_valid and counts the frame. A bad frame pulses o_frame_err and
//   counts the error.
// Ports:
//   i_clk           e-link clock (40 MHz)
//   i_rst           synchronous active-low reset
//   i_enable        receiver enable; low returns to HUNT
//   i_rx_elink2bit  serial dibit, bit[1] earlier in time
//   o_data_out      last good 76-bit frame payload
//   o_data_valid    one-cycle pulse per good frame
//   o_frame_err     one-cycle pulse per rejected frame
//   o_locked        high while in PAYLOAD or EOP
//   o_frame_cnt     good-frame count, wraps
//   o_err_cnt       error count, saturates at 255
module elink_frame_rx76
  import mopshub_elink_pkg::*;
#(
  parameter int FRAME_BYTES = 10,
  parameter int CNT_W       = 16
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_enable,
  input  logic [1:0]          i_rx_elink2bit,
  output logic [UPLINK_W-1:0] o_data_out,
  output logic                o_data_valid,
  output logic                o_frame_err,
  output logic                o_locked,
  output logic [CNT_W-1:0]    o_frame_cnt,
  output logic [7:0]          o_err_cnt
);

  localparam int WORD_W = FRAME_BYTES * 8;
  localparam int BCNT_W = $clog2(FRAME_BYTES + 1);

  elink_rx_state_t     r_state, w_next_state;
  logic [7:0]          w_byte_q;
  logic                w_byte_strobe;
  logic                w_sop_match;
  logic                w_load_byte;
  logic                w_good;
  logic                w_bad;
  logic [WORD_W-1:0]   r_word;
  logic [BCNT_W-1:0]   r_byte_cnt;
  logic [UPLINK_W-1:0] r_data_out;
  logic                r_data_valid;
  logic                r_frame_err;
  logic [CNT_W-1:0]    r_frame_cnt;
  logic [7:0]          r_err_cnt;

  elink_dibit_deser u_deser (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_realign     (w_sop_match),
    .i_dibit       (i_rx_elink2bit),
    .o_byte_q      (w_byte_q),
    .o_byte_strobe (w_byte_strobe)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // In HUNT, the shift register is compared on every cycle. This finds SOP at
  // any dibit alignment. Once locked, only strobed bytes matter. Any SOP or
  // IDLE inside the payload is therefore taken as plain data.
  always_comb begin
    w_next_state = r_state;
    w_sop_match  = 1'b0;
    w_load_byte  = 1'b0;
    w_good       = 1'b0;
    w_bad        = 1'b0;
    if (!i_enable) begin
      w_next_state = HUNT;
    end else begin
      case (r_state)
        HUNT: begin
          if (w_byte_q == ELINK_SOP) begin
            w_sop_match  = 1'b1;
            w_next_state = PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_byte_strobe) begin
            w_load_byte = 1'b1;
            if (r_byte_cnt == BCNT_W'(FRAME_BYTES - 1)) begin
              w_next_state = EOP;
            end
          end
        end
        EOP: begin
          if (w_byte_strobe) begin
            if ((w_byte_q == ELINK_EOP) && (r_word[WORD_W-1:UPLINK_W] == '0)) begin
              w_good = 1'b1;
            end else begin
              w_bad = 1'b1;
            end
            w_next_state = HUNT;
          end
        end
        default: w_next_state = HUNT;
      endcase
    end
  end

  // Payload bytes shift in MSB-first, so byte 0 ends up in the top of r_word.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_word       <= '0;
      r_byte_cnt   <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_frame_cnt  <= '0;
      r_err_cnt    <= '0;
    end else begin
      r_data_valid <= w_good;
      r_frame_err  <= w_bad;
      if (w_sop_match) begin
        r_byte_cnt <= '0;
      end else if (w_load_byte) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      if (w_load_byte) begin
        r_word <= {r_word[WORD_W-9:0], w_byte_q};
      end
      if (w_good) begin
        r_data_out  <= r_word[UPLINK_W-1:0];
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end
      if (w_bad && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_frame_err  = r_frame_err;
  assign o_locked     = (r_state != HUNT);
  assign o_frame_cnt  = r_frame_cnt;
  assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_elink_frame_rx76.sv
// tb_elink_frame_rx76
//   Directed bench for elink_frame_rx76. A table of frames is applied, each
//   with its expected pulse and counter values. Hand-written sequences then
//   cover back-to-back frames, enable drop, reset mid-payload and
//   error-counter saturation.
module tb_elink_frame_rx76;
  import mopshub_elink_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_enable = 1'b1;
  logic [1:0]  i_rx = 2'b00;
  logic [75:0] o_data_out;
  logic        o_data_valid;
  logic        o_frame_err;
  logic        o_locked;
  logic [15:0] o_frame_cnt;
  logic [7:0]  o_err_cnt;

  int assertCount = 0;
  int failCount = 0;
  int cycleCount = 0;
  int validCount = 0;
  int errCount = 0;
  int lastValidCycle = -1;
  int lastErrCycle = -1;
  int validCycles[$];
  int idlePhase = 0;

  typedef struct {
    int          prefix;
    logic [79:0] payload;
    logic [7:0]  eop;
    bit          expValid;
    logic [75:0] expData;
    int          expFcnt;
    int          expEcnt;
  } vec_t;

  vec_t vecs[6];

  elink_frame_rx76 #(.FRAME_BYTES(10), .CNT_W(16)) dut (
    .i_clk          (clk),
    .i_rst          (i_rst),
    .i_enable       (i_enable),
    .i_rx_elink2bit (i_rx),
    .o_data_out     (o_data_out),
    .o_data_valid   (o_data_valid),
    .o_frame_err    (o_frame_err),
    .o_locked       (o_locked),
    .o_frame_cnt    (o_frame_cnt),
    .o_err_cnt      (o_err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  always @(negedge clk) begin
    if (o_data_valid) begin
      validCount++;
      lastValidCycle = cycleCount;
      validCycles.push_back(cycleCount);
    end
    if (o_frame_err) begin
      errCount++;
      lastErrCycle = cycleCount;
    end
  end

  task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic sendDibit(input logic [1:0] d);
    i_rx = d;
    @(posedge clk);
    #1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    for (int k = 3; k >= 0; k--) sendDibit(b[2*k+1 -: 2]);
  endtask

  task automatic sendIdle(input int n);
    logic [7:0] idle;
    idle = ELINK_IDLE;
    for (int k = 0; k < n; k++) begin
      sendDibit(idle[7-2*idlePhase -: 2]);
      idlePhase = (idlePhase + 1) % 4;
    end
  endtask

  // Sends SOP, ten payload bytes and the given end byte. It returns the cycle
  // of the edge that sampled the last end-byte dibit.
  task automatic applyStimulus(input logic [79:0] payload, input logic [7:0] eop, output int eCycle);
    idlePhase = 0;
    sendByte(ELINK_SOP);
    for (int j = 9; j >= 0; j--) sendByte(payload[8*j+7 -: 8]);
    sendByte(eop);
    eCycle = cycleCount;
  endtask

  initial begin
    int eCyc;
    int e3;
    int vc0;
    int ec0;
    logic [79:0] pl;

    vecs[0] = '{100, 80'h0012_3456_789A_BCDE_F012, 8'hDC, 1'b1, 76'h012_3456_789A_BCDE_F012, 1, 0};
    vecs[1] = '{8,   80'h0FED_CBA9_8765_4321_0ABC, 8'hBC, 1'b0, 76'h012_3456_789A_BCDE_F012, 1, 1};
    vecs[2] = '{8,   80'h0A5A_5A5A_5A5A_5A5A_5A5A, 8'hDC, 1'b1, 76'hA5A_5A5A_5A5A_5A5A_5A5A, 2, 1};
    vecs[3] = '{8,   80'hF100_0000_0000_0000_0001, 8'hDC, 1'b0, 76'hA5A_5A5A_5A5A_5A5A_5A5A, 2, 2};
    vecs[4] = '{5,   80'h0B3C_113C_22BC_33DC_4455, 8'hDC, 1'b1, 76'hB3C_113C_22BC_33DC_4455, 3, 2};
    vecs[5] = '{7,   80'h0FFF_FFFF_FFFF_FFFF_FFFF, 8'hDC, 1'b1, 76'hFFF_FFFF_FFFF_FFFF_FFFF, 4, 2};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    checkOutput("rst_data_out", 80'(o_data_out), 80'h0);
    checkOutput("rst_valid", 80'(o_data_valid), 80'h0);
    checkOutput("rst_err", 80'(o_frame_err), 80'h0);
    checkOutput("rst_locked", 80'(o_locked), 80'h0);
    checkOutput("rst_frame_cnt", 80'(o_frame_cnt), 80'h0);
    checkOutput("rst_err_cnt", 80'(o_err_cnt), 80'h0);
    i_rst = 1'b1;

    // Table-driven frames
    for (int v = 0; v < 6; v++) begin
      vc0 = validCount;
      ec0 = errCount;
      idlePhase = 0;
      sendIdle(vecs[v].prefix);
      applyStimulus(vecs[v].payload, vecs[v].eop, eCyc);
      checkOutput($sformatf("v%0d_no_pulse_at_E", v), 80'({o_data_valid, o_frame_err}), 80'h0);
      sendIdle(1);
      checkOutput($sformatf("v%0d_valid_E1", v), 80'(o_data_valid), 80'(vecs[v].expValid));
      checkOutput($sformatf("v%0d_err_E1", v), 80'(o_frame_err), 80'(!vecs[v].expValid));
      checkOutput($sformatf("v%0d_data_out", v), 80'(o_data_out), 80'(vecs[v].expData));
      checkOutput($sformatf("v%0d_frame_cnt", v), 80'(o_frame_cnt), 80'(vecs[v].expFcnt));
      checkOutput($sformatf("v%0d_err_cnt", v), 80'(o_err_cnt), 80'(vecs[v].expEcnt));
      checkOutput($sformatf("v%0d_unlocked", v), 80'(o_locked), 80'h0);
      sendIdle(7);
      checkOutput($sformatf("v%0d_valid_pulses", v), 80'(validCount - vc0), 80'(vecs[v].expValid));
      checkOutput($sformatf("v%0d_err_pulses", v), 80'(errCount - ec0), 80'(!vecs[v].expValid));
      if (vecs[v].expValid) checkOutput($sformatf("v%0d_valid_cycle", v), 80'(lastValidCycle), 80'(eCyc + 1));
      else checkOutput($sformatf("v%0d_err_cycle", v), 80'(lastErrCycle), 80'(eCyc + 1));
    end

    // Three frames back-to-back, no IDLE between them
    validCycles.delete();
    applyStimulus(80'h0111_2222_3333_4444_5555, 8'hDC, eCyc);
    applyStimulus(80'h0666_7777_8888_9999_AAAA, 8'hDC, eCyc);
    applyStimulus(80'h0BBB_CCCC_DDDD_EEEE_FFFF, 8'hDC, e3);
    sendIdle(8);
    checkOutput("b2b_pulses", 80'(validCycles.size()), 80'd3);
    if (validCycles.size() == 3) begin
      checkOutput("b2b_gap1", 80'(validCycles[1] - validCycles[0]), 80'd48);
      checkOutput("b2b_gap2", 80'(validCycles[2] - validCycles[1]), 80'd48);
      checkOutput("b2b_last_cycle", 80'(validCycles[2]), 80'(e3 + 1));
    end
    checkOutput("b2b_data_out", 80'(o_data_out), 80'(76'hBBB_CCCC_DDDD_EEEE_FFFF));
    checkOutput("b2b_frame_cnt", 80'(o_frame_cnt), 80'd7);

    // Enable dropped mid-payload: the frame is discarded silently
    vc0 = validCount;
    ec0 = errCount;
    idlePhase = 0;
    sendIdle(8);
    sendByte(ELINK_SOP);
    sendByte(8'h01);
    sendByte(8'h02);
    checkOutput("en_locked_before", 80'(o_locked), 80'h1);
    i_enable = 1'b0;
    sendIdle(2);
    checkOutput("en_locked_off", 80'(o_locked), 80'h0);
    sendIdle(60);
    i_enable = 1'b1;
    sendIdle(8);
    checkOutput("en_no_valid", 80'(validCount - vc0), 80'h0);
    checkOutput("en_no_err", 80'(errCount - ec0), 80'h0);
    checkOutput("en_counts", 80'({o_frame_cnt, o_err_cnt}), 80'({16'd7, 8'd2}));
    checkOutput("en_data_held", 80'(o_data_out), 80'(76'hBBB_CCCC_DDDD_EEEE_FFFF));

    // Reset mid-payload (during byte 5)
    vc0 = validCount;
    ec0 = errCount;
    pl = 80'h0123_4567_89AB_CDEF_0011;
    idlePhase = 0;
    sendIdle(8);
    sendByte(ELINK_SOP);
    checkOutput("lock_at_sop_edge", 80'(o_locked), 80'h0);
    sendDibit(pl[79:78]);
    checkOutput("lock_after_sop", 80'(o_locked), 80'h1);
    sendDibit(pl[77:76]);
    sendDibit(pl[75:74]);
    sendDibit(pl[73:72]);
    for (int j = 8; j >= 5; j--) sendByte(pl[8*j+7 -: 8]);
    sendDibit(pl[39:38]);
    i_rst = 1'b0;
    sendIdle(4);
    checkOutput("midrst_data_out", 80'(o_data_out), 80'h0);
    checkOutput("midrst_counts", 80'({o_frame_cnt, o_err_cnt}), 80'h0);
    checkOutput("midrst_locked", 80'(o_locked), 80'h0);
    checkOutput("midrst_pulses", 80'({o_data_valid, o_frame_err}), 80'h0);
    i_rst = 1'b1;
    sendIdle(8);
    applyStimulus(pl, 8'hDC, eCyc);
    sendIdle(8);
    checkOutput("postrst_valid_pulses", 80'(validCount - vc0), 80'd1);
    checkOutput("postrst_err_pulses", 80'(errCount - ec0), 80'd0);
    checkOutput("postrst_valid_cycle", 80'(lastValidCycle), 80'(eCyc + 1));
    checkOutput("postrst_data_out", 80'(o_data_out), 80'(76'h123_4567_89AB_CDEF_0011));
    checkOutput("postrst_frame_cnt", 80'(o_frame_cnt), 80'd1);
    checkOutput("postrst_err_cnt", 80'(o_err_cnt), 80'd0);

    // 256 bad frames saturate the error counter
    ec0 = errCount;
    for (int n = 0; n < 256; n++) applyStimulus(80'h0000_0000_0000_0000_0000 | 80'(n), 8'hBC, eCyc);
    sendIdle(8);
    checkOutput("sat_err_pulses", 80'(errCount - ec0), 80'd256);
    checkOutput("sat_err_cnt", 80'(o_err_cnt), 80'd255);
    checkOutput("sat_frame_cnt", 80'(o_frame_cnt), 80'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
